warp_barrier_unit: RTL and testbench

- Scheduler-side consumer of the barrier field of the warp-control bundle driven by the execute-stage warp-control master.
- Tracks per-barrier arrival masks, stalls arriving warps, and releases them when the expected count is reached.
- Barriers flagged global are forwarded to the cluster over a req/rsp handshake before release.
- Feeds the stall mask into the scheduler's issue-eligibility logic.

---
 rtl/warp_barrier_unit.sv | 223 ++++++++++++++++++++++
 tb/tb_warp_barrier_unit.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/warp_barrier_unit.sv
// Barrier tracking for the warp scheduler: records per-barrier arrivals, stalls
// arriving warps, releases them locally or after a cluster-level global handshake.
module warp_barrier_unit #(
    parameter int NUM_WARPS    = 4,
    parameter int NUM_BARRIERS = 4,
    parameter int NW_WIDTH     = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    parameter int NB_WIDTH     = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 warp_ctl_valid,
    input  logic [NW_WIDTH-1:0]  warp_ctl_wid,
    input  logic                 bar_valid,
    input  logic [NB_WIDTH-1:0]  bar_id,
    input  logic                 bar_is_global,
    input  logic                 bar_is_noop,
    input  logic [NW_WIDTH-1:0]  bar_size_m1,
    output logic                 gbar_req_valid,
    output logic [NB_WIDTH-1:0]  gbar_req_id,
    input  logic                 gbar_req_ready,
    input  logic                 gbar_rsp_valid,
    input  logic [NB_WIDTH-1:0]  gbar_rsp_id,
    output logic [NUM_WARPS-1:0] stalled_warps,
    output logic                 release_valid,
    output logic [NUM_WARPS-1:0] release_mask
);

    localparam int CW = NW_WIDTH + 1;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [NUM_WARPS-1:0]    NO_WARPS = {NUM_WARPS{1'b0}};
    localparam logic [NUM_BARRIERS-1:0] NO_BARS  = {NUM_BARRIERS{1'b0}};

    function automatic logic [NUM_WARPS-1:0] warp_onehot(input logic [NW_WIDTH-1:0] idx);
        logic [NUM_WARPS-1:0] v;
        for (int i = 0; i < NUM_WARPS; i++) begin
            if (idx == NW_WIDTH'(i)) v[i] = 1'b1;
            else                     v[i] = 1'b0;
        end
        return v;
    endfunction

    function automatic logic [NUM_BARRIERS-1:0] bar_onehot(input logic [NB_WIDTH-1:0] idx);
        logic [NUM_BARRIERS-1:0] v;
        for (int i = 0; i < NUM_BARRIERS; i++) begin
            if (idx == NB_WIDTH'(i)) v[i] = 1'b1;
            else                     v[i] = 1'b0;
        end
        return v;
    endfunction

    function automatic logic [CW-1:0] popcount(input logic [NUM_WARPS-1:0] v);
        logic [CW-1:0] c;
        c = {CW{1'b0}};
        for (int i = 0; i < NUM_WARPS; i++) begin
            c = c + CW'(v[i]);
        end
        return c;
    endfunction

    // Descending scan so the last hit, i.e. the lowest index, wins.
    function automatic logic [NB_WIDTH-1:0] lowest_set(input logic [NUM_BARRIERS-1:0] v);
        logic [NB_WIDTH-1:0] idx;
        idx = {NB_WIDTH{1'b0}};
        for (int i = NUM_BARRIERS - 1; i >= 0; i--) begin
            if (v[i]) idx = NB_WIDTH'(i);
            else      idx = idx;
        end
        return idx;
    endfunction

    logic [NUM_WARPS-1:0]    mask_r [NUM_BARRIERS];
    logic [NUM_BARRIERS-1:0] pending_r;
    logic [1:0]              state_r;
    logic [NB_WIDTH-1:0]     gid_r;
    logic                    gbar_req_valid_r;
    logic [NUM_WARPS-1:0]    stalled_r;
    logic                    release_valid_r;
    logic [NUM_WARPS-1:0]    release_mask_r;
    logic                    hold_valid_r;
    logic [NUM_WARPS-1:0]    hold_mask_r;

    logic                    arrival_s;
    logic [NUM_WARPS-1:0]    wid_bit_s;
    logic [NUM_WARPS-1:0]    cur_mask_s;
    logic [NUM_WARPS-1:0]    new_mask_s;
    logic                    dup_s;
    logic                    busy_s;
    logic                    accept_s;
    logic [CW-1:0]           size_s;
    logic                    complete_s;
    logic                    local_done_s;
    logic                    global_done_s;
    logic                    stall_set_s;
    logic [NUM_WARPS-1:0]    gl_mask_s;
    logic                    gl_release_s;
    logic                    req_accept_s;
    logic [NUM_WARPS-1:0]    stalled_next_s;

    // Arrival classification; a barrier owned by the global path ignores arrivals.
    always_comb begin
        arrival_s     = warp_ctl_valid & bar_valid & ~bar_is_noop;
        wid_bit_s     = warp_onehot(warp_ctl_wid);
        cur_mask_s    = mask_r[bar_id];
        new_mask_s    = cur_mask_s | wid_bit_s;
        dup_s         = |(cur_mask_s & wid_bit_s);
        busy_s        = pending_r[bar_id] | ((state_r != ST_IDLE) & (gid_r == bar_id));
        accept_s      = arrival_s & ~dup_s & ~busy_s;
        size_s        = {1'b0, bar_size_m1} + {{NW_WIDTH{1'b0}}, 1'b1};
        complete_s    = popcount(new_mask_s) >= size_s;
        local_done_s  = accept_s & complete_s & ~bar_is_global;
        global_done_s = accept_s & complete_s & bar_is_global;
        stall_set_s   = accept_s & ~local_done_s;
        gl_mask_s     = mask_r[gid_r];
        gl_release_s  = (state_r == ST_WAIT) & gbar_rsp_valid & (gbar_rsp_id == gid_r);
        req_accept_s  = (state_r == ST_REQ) & gbar_req_ready;
    end

    // Next stall vector: set the newly blocked warp, drop members of any released barrier.
    always_comb begin
        stalled_next_s = (stalled_r | (stall_set_s ? wid_bit_s : NO_WARPS))
                       & ~(local_done_s ? cur_mask_s : NO_WARPS)
                       & ~(gl_release_s ? gl_mask_s : NO_WARPS);
    end

    // Per-barrier arrival masks.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < NUM_BARRIERS; b++) begin
                mask_r[b] <= NO_WARPS;
            end
        end else begin
            for (int b = 0; b < NUM_BARRIERS; b++) begin
                if (accept_s && (bar_id == NB_WIDTH'(b))) begin
                    mask_r[b] <= local_done_s ? NO_WARPS : new_mask_s;
                end else if (gl_release_s && (gid_r == NB_WIDTH'(b))) begin
                    mask_r[b] <= NO_WARPS;
                end else begin
                    mask_r[b] <= mask_r[b];
                end
            end
        end
    end

    // Stall vector register.
    always_ff @(posedge clk) begin
        if (reset) begin
            stalled_r <= NO_WARPS;
        end else begin
            stalled_r <= stalled_next_s;
        end
    end

    // Global barrier FSM and pending set; one request outstanding at a time.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r          <= ST_IDLE;
            gid_r            <= {NB_WIDTH{1'b0}};
            pending_r        <= NO_BARS;
            gbar_req_valid_r <= 1'b0;
        end else begin
            pending_r <= (pending_r & ~(req_accept_s ? bar_onehot(gid_r) : NO_BARS))
                       | (global_done_s ? bar_onehot(bar_id) : NO_BARS);
            case (state_r)
                ST_IDLE: begin
                    if (|pending_r) begin
                        gid_r            <= lowest_set(pending_r);
                        state_r          <= ST_REQ;
                        gbar_req_valid_r <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (gbar_req_ready) begin
                        state_r          <= ST_WAIT;
                        gbar_req_valid_r <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (gl_release_s) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r          <= ST_IDLE;
                    gbar_req_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Release pulse: global release first, then the held local pulse, then a fresh local one.
    always_ff @(posedge clk) begin
        if (reset) begin
            release_valid_r <= 1'b0;
            release_mask_r  <= NO_WARPS;
            hold_valid_r    <= 1'b0;
            hold_mask_r     <= NO_WARPS;
        end else if (gl_release_s) begin
            release_valid_r <= 1'b1;
            release_mask_r  <= gl_mask_s;
            hold_valid_r    <= local_done_s;
            hold_mask_r     <= local_done_s ? new_mask_s : NO_WARPS;
        end else if (hold_valid_r) begin
            release_valid_r <= 1'b1;
            release_mask_r  <= hold_mask_r;
            hold_valid_r    <= local_done_s;
            hold_mask_r     <= local_done_s ? new_mask_s : NO_WARPS;
        end else begin
            release_valid_r <= local_done_s;
            release_mask_r  <= local_done_s ? new_mask_s : NO_WARPS;
            hold_valid_r    <= 1'b0;
            hold_mask_r     <= NO_WARPS;
        end
    end

    assign gbar_req_valid = gbar_req_valid_r;
    assign gbar_req_id    = gid_r;
    assign stalled_warps  = stalled_r;
    assign release_valid  = release_valid_r;
    assign release_mask   = release_mask_r;

endmodule

// File: tb/tb_warp_barrier_unit.sv
// Directed bench for warp_barrier_unit: a set/queue-based reference model checked
// every cycle, plus literal expectations at each step of the directed sequence.
module tb_warp_barrier_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       warp_ctl_valid;
    logic [1:0] warp_ctl_wid;
    logic       bar_valid;
    logic [1:0] bar_id;
    logic       bar_is_global;
    logic       bar_is_noop;
    logic [1:0] bar_size_m1;
    logic       gbar_req_valid;
    logic [1:0] gbar_req_id;
    logic       gbar_req_ready;
    logic       gbar_rsp_valid;
    logic [1:0] gbar_rsp_id;
    logic [3:0] stalled_warps;
    logic       release_valid;
    logic [3:0] release_mask;

    always #5 clk = ~clk;

    warp_barrier_unit dut (
        .clk            (clk),
        .reset          (reset),
        .warp_ctl_valid (warp_ctl_valid),
        .warp_ctl_wid   (warp_ctl_wid),
        .bar_valid      (bar_valid),
        .bar_id         (bar_id),
        .bar_is_global  (bar_is_global),
        .bar_is_noop    (bar_is_noop),
        .bar_size_m1    (bar_size_m1),
        .gbar_req_valid (gbar_req_valid),
        .gbar_req_id    (gbar_req_id),
        .gbar_req_ready (gbar_req_ready),
        .gbar_rsp_valid (gbar_rsp_valid),
        .gbar_rsp_id    (gbar_rsp_id),
        .stalled_warps  (stalled_warps),
        .release_valid  (release_valid),
        .release_mask   (release_mask)
    );

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: member sets per barrier, set of pending globals,
    // the single outstanding global, and a queue of release pulses.
    bit [3:0] m_mask [4];
    bit [3:0] m_pend, m_stall, pend_pre, new_pend, members, gl;
    int       m_out = -1;
    bit       m_req, req_pre;
    int       out_pre, b_i, w_i, lo;
    bit [3:0] m_relq [$];
    bit       e_rel_v;
    bit [3:0] e_rel_m;

    always @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < 4; b++) m_mask[b] = 4'b0000;
            m_pend = 4'b0000; m_stall = 4'b0000; m_out = -1; m_req = 1'b0;
            m_relq.delete(); e_rel_v = 1'b0; e_rel_m = 4'b0000;
        end else begin
            out_pre = m_out; req_pre = m_req; pend_pre = m_pend; new_pend = 4'b0000;
            if (warp_ctl_valid && bar_valid && !bar_is_noop) begin
                b_i = int'(bar_id);
                w_i = int'(warp_ctl_wid);
                if (!(pend_pre[b_i] || out_pre == b_i || m_mask[b_i][w_i])) begin
                    members = m_mask[b_i] | (4'b0001 << w_i);
                    if ($countones(members) >= int'(bar_size_m1) + 1) begin
                        if (bar_is_global) begin
                            m_mask[b_i] = members; m_stall[w_i] = 1'b1; new_pend[b_i] = 1'b1;
                        end else begin
                            m_mask[b_i] = 4'b0000; m_stall = m_stall & ~members;
                            m_relq.push_back(members);
                        end
                    end else begin
                        m_mask[b_i] = members; m_stall[w_i] = 1'b1;
                    end
                end
            end
            if (out_pre >= 0 && !req_pre && gbar_rsp_valid && int'(gbar_rsp_id) == out_pre) begin
                gl = m_mask[out_pre];
                m_mask[out_pre] = 4'b0000;
                m_stall = m_stall & ~gl;
                m_out = -1;
                m_relq.push_front(gl);
            end
            if (out_pre >= 0 && req_pre && gbar_req_ready) m_req = 1'b0;
            if (out_pre < 0 && pend_pre != 4'b0000) begin
                lo = 0;
                for (int i = 3; i >= 0; i--) if (pend_pre[i]) lo = i;
                m_out = lo; m_pend[lo] = 1'b0; m_req = 1'b1;
            end
            m_pend = m_pend | new_pend;
            if (m_relq.size() > 0) begin
                e_rel_v = 1'b1; e_rel_m = m_relq.pop_front();
            end else begin
                e_rel_v = 1'b0; e_rel_m = 4'b0000;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            chk("model_stalled", stalled_warps, m_stall);
            chk("model_rel_valid", {3'b000, release_valid}, {3'b000, e_rel_v});
            if (e_rel_v) chk("model_rel_mask", release_mask, e_rel_m);
            chk("model_req_valid", {3'b000, gbar_req_valid}, {3'b000, m_req});
            if (m_req) chk("model_req_id", {2'b00, gbar_req_id}, 4'(m_out));
        end
    end

    task automatic arrive(input int w, input int b, input int sm1, input bit glob, input bit noop);
        warp_ctl_valid = 1'b1; bar_valid = 1'b1;
        warp_ctl_wid = 2'(w); bar_id = 2'(b); bar_size_m1 = 2'(sm1);
        bar_is_global = glob; bar_is_noop = noop;
        @(posedge clk); #1;
        warp_ctl_valid = 1'b0; bar_valid = 1'b0; bar_is_global = 1'b0; bar_is_noop = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic rsp(input int id);
        gbar_rsp_valid = 1'b1; gbar_rsp_id = 2'(id);
        @(posedge clk); #1;
        gbar_rsp_valid = 1'b0;
    endtask

    task automatic chk_rel(input string name, input logic [3:0] m);
        chk({name, "_valid"}, {3'b000, release_valid}, 4'b0001);
        chk({name, "_mask"}, release_mask, m);
    endtask

    initial begin
        reset = 1'b1; warp_ctl_valid = 1'b0; warp_ctl_wid = 2'd0; bar_valid = 1'b0;
        bar_id = 2'd0; bar_is_global = 1'b0; bar_is_noop = 1'b0; bar_size_m1 = 2'd0;
        gbar_req_ready = 1'b0; gbar_rsp_valid = 1'b0; gbar_rsp_id = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        started = 1'b1;
        chk("reset_stalled", stalled_warps, 4'b0000);
        chk("reset_rel_valid", {3'b000, release_valid}, 4'b0000);
        chk("reset_req_valid", {3'b000, gbar_req_valid}, 4'b0000);
        reset = 1'b0;

        // Local barrier 1, four warps
        arrive(0, 1, 3, 1'b0, 1'b0); chk("t1_stall_a", stalled_warps, 4'b0001);
        arrive(1, 1, 3, 1'b0, 1'b0); chk("t1_stall_b", stalled_warps, 4'b0011);
        arrive(2, 1, 3, 1'b0, 1'b0); chk("t1_stall_c", stalled_warps, 4'b0111);
        chk("t1_no_rel", {3'b000, release_valid}, 4'b0000);
        arrive(3, 1, 3, 1'b0, 1'b0); chk_rel("t1_rel", 4'b1111);
        chk("t1_stall_clr", stalled_warps, 4'b0000);
        idle(1); chk("t1_pulse_end", {3'b000, release_valid}, 4'b0000);

        // Size one: immediate release, never stalled
        arrive(2, 0, 0, 1'b0, 1'b0); chk_rel("t2_rel", 4'b0100);
        chk("t2_stall", stalled_warps, 4'b0000);
        idle(1);

        // Global barrier 2 with backpressure and a foreign response
        arrive(0, 2, 1, 1'b1, 1'b0); chk("t3_stall_a", stalled_warps, 4'b0001);
        arrive(1, 2, 1, 1'b1, 1'b0); chk("t3_stall_b", stalled_warps, 4'b0011);
        chk("t3_no_rel", {3'b000, release_valid}, 4'b0000);
        idle(1); chk("t3_req", {3'b000, gbar_req_valid}, 4'b0001);
        chk("t3_req_id", {2'b00, gbar_req_id}, 4'd2);
        idle(2); chk("t3_req_held", {3'b000, gbar_req_valid}, 4'b0001);
        chk("t3_req_id_held", {2'b00, gbar_req_id}, 4'd2);
        gbar_req_ready = 1'b1; idle(1); gbar_req_ready = 1'b0;
        chk("t3_req_drop", {3'b000, gbar_req_valid}, 4'b0000);
        rsp(3); chk("t3_wrong_id", {3'b000, release_valid}, 4'b0000);
        chk("t3_still_stalled", stalled_warps, 4'b0011);
        rsp(2); chk_rel("t3_rel", 4'b0011);
        chk("t3_stall_clr", stalled_warps, 4'b0000);
        idle(1);

        // Two global barriers completing back to back
        gbar_req_ready = 1'b1;
        arrive(0, 0, 0, 1'b1, 1'b0); chk("t4_stall_a", stalled_warps, 4'b0001);
        arrive(1, 3, 0, 1'b1, 1'b0); chk("t4_req0", {2'b00, gbar_req_id}, 4'd0);
        chk("t4_req0_v", {3'b000, gbar_req_valid}, 4'b0001);
        idle(1); chk("t4_req0_done", {3'b000, gbar_req_valid}, 4'b0000);
        rsp(0); chk_rel("t4_rel0", 4'b0001);
        chk("t4_no_overlap", {3'b000, gbar_req_valid}, 4'b0000);
        idle(1); chk("t4_req3", {2'b00, gbar_req_id}, 4'd3);
        chk("t4_req3_v", {3'b000, gbar_req_valid}, 4'b0001);
        idle(1);
        rsp(3); chk_rel("t4_rel3", 4'b0010);
        chk("t4_stall_clr", stalled_warps, 4'b0000);
        gbar_req_ready = 1'b0;
        idle(1);

        // Duplicate and no-op arrivals
        arrive(1, 0, 1, 1'b0, 1'b0); chk("t5_stall", stalled_warps, 4'b0010);
        arrive(1, 0, 1, 1'b0, 1'b0); chk("t5_dup_no_rel", {3'b000, release_valid}, 4'b0000);
        arrive(3, 0, 0, 1'b0, 1'b1); chk("t5_noop_no_rel", {3'b000, release_valid}, 4'b0000);
        chk("t5_noop_stall", stalled_warps, 4'b0010);
        arrive(2, 0, 1, 1'b0, 1'b0); chk_rel("t5_rel", 4'b0110);
        idle(1);

        // Global release colliding with a local completion
        arrive(0, 2, 1, 1'b1, 1'b0);
        arrive(1, 2, 1, 1'b1, 1'b0);
        idle(1);
        gbar_req_ready = 1'b1; idle(1); gbar_req_ready = 1'b0;
        arrive(2, 0, 1, 1'b0, 1'b0); chk("t6_stall", stalled_warps, 4'b0111);
        gbar_rsp_valid = 1'b1; gbar_rsp_id = 2'd2;
        arrive(3, 0, 1, 1'b0, 1'b0);
        gbar_rsp_valid = 1'b0;
        chk_rel("t6_rel_global", 4'b0011);
        chk("t6_stall_clr", stalled_warps, 4'b0000);
        idle(1); chk_rel("t6_rel_local", 4'b1100);
        idle(1); chk("t6_pulse_end", {3'b000, release_valid}, 4'b0000);

        // Reset mid-operation
        arrive(0, 1, 3, 1'b0, 1'b0);
        arrive(2, 1, 3, 1'b0, 1'b0); chk("t7_stall", stalled_warps, 4'b0101);
        reset = 1'b1; idle(1); reset = 1'b0;
        chk("t7_rst_stall", stalled_warps, 4'b0000);
        chk("t7_rst_rel", {3'b000, release_valid}, 4'b0000);
        chk("t7_rst_req", {3'b000, gbar_req_valid}, 4'b0000);
        rsp(0); chk("t7_rsp_ignored", {3'b000, release_valid}, 4'b0000);
        arrive(0, 1, 1, 1'b0, 1'b0); chk("t7_mask_cleared", stalled_warps, 4'b0001);
        arrive(1, 1, 1, 1'b0, 1'b0); chk_rel("t7_rel", 4'b0011);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
